// File: rtl/fc_neuron_stream.sv
// Streaming fully-connected neuron: serial MAC over N_IN beats, bias add, saturate, valid/ready result.
// Optional macro FC_NEURON_RELU_EN clamps negative results to zero.
module fc_neuron_stream #(
    parameter int unsigned N_IN  = 3136,
    parameter int unsigned IN_W  = 30,
    parameter int unsigned W_W   = 9,
    parameter int unsigned B_W   = 9,
    parameter int unsigned ACC_W = 52,
    parameter int unsigned OUT_W = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [B_W-1:0]   bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_act,
    input  logic [W_W-1:0]   in_w,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             len_err,
    output logic             busy
);

    localparam int unsigned PROD_W = IN_W + W_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [B_W-1:0]     bias_q, bias_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               len_err_q, len_err_d;

    logic signed [PROD_W-1:0] prod;
    logic [SUM_W-1:0]         sum;
    logic                     beat_ok;
    logic                     last_beat;
    logic                     sat_hi;
    logic                     sat_lo;

    assign prod      = $signed(in_act) * $signed(in_w);
    assign beat_ok   = in_valid & in_ready_q;
    assign last_beat = (cnt_q == LAST_CNT);
    assign sum       = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                     + {{(SUM_W-B_W){bias_q[B_W-1]}}, bias_q};
    // Overflow of the OUT_W window: bits above the output sign bit disagree with the true sign.
    assign sat_hi    = ~sum[SUM_W-1] &  (|sum[SUM_W-2:OUT_W-1]);
    assign sat_lo    =  sum[SUM_W-1] & ~(&sum[SUM_W-2:OUT_W-1]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bias_d      = bias_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        len_err_d   = len_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat_ok) begin
                    acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_last != last_beat) begin
                        len_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
`ifdef FC_NEURON_RELU_EN
                if (sum[SUM_W-1]) begin
                    out_data_d = '0;
                    out_sat_d  = 1'b0;
                end else if (sat_hi) begin
`else
                if (sat_hi) begin
`endif
                    out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
                    out_sat_d  = 1'b1;
                end else if (sat_lo) begin
                    out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = sum[OUT_W-1:0];
                    out_sat_d  = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_ACCUM);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            len_err_q   <= len_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign len_err   = len_err_q;
    assign busy      = busy_q;

endmodule
